// File: rtl/core_status_unit_pkg.sv
// Shared definitions for the Q2A03 status register: flag bit positions,
// flag instruction encodings and the P reset image.
package core_status_signals;

   localparam int flag_c = 0;
   localparam int flag_z = 1;
   localparam int flag_i = 2;
   localparam int flag_d = 3;
   localparam int flag_b = 4;
   localparam int flag_u = 5;
   localparam int flag_v = 6;
   localparam int flag_n = 7;

   localparam logic [7:0] RESET_P = 8'h24;

   // Bits 5/4 have no storage; bit 5 always reads as 1, bit 4 as 0.
   localparam logic [7:0] stored_mask = 8'hCF;
   localparam logic [7:0] fixed_ones  = 8'h20;

   typedef enum logic [2:0] {
      op_none = 3'd0,
      op_clc  = 3'd1,
      op_sec  = 3'd2,
      op_cli  = 3'd3,
      op_sei  = 3'd4,
      op_cld  = 3'd5,
      op_sed  = 3'd6,
      op_clv  = 3'd7
   } flag_op_type;

   function automatic logic [7:0] flag_bit(input int idx);
      flag_bit = 8'h01 << idx;
   endfunction

endpackage

// File: rtl/core_status_unit_if.sv
// Bundle between the ALU/sequencer (master) and the status unit (slave).
interface core_status_unit_if;
   import core_status_signals::*;

   logic        alu_valid;
   logic [7:0]  alu_result;
   logic [7:0]  alu_rhs;
   logic        alu_carry;
   logic        alu_overflow;
   logic [3:0]  alu_flag_we;
   logic        alu_nv_from_rhs;
   flag_op_type flag_op;
   logic        p_load;
   logic        p_load_fast;
   logic [7:0]  p_load_data;
   logic        push_brk;
   logic [7:0]  p_flags;
   logic [7:0]  p_push;
   logic        nmi_n;
   logic        irq_n;
   logic        poll;
   logic        int_pending;
   logic        int_is_nmi;
   logic        int_ack;

   modport master (
      output alu_valid, alu_result, alu_rhs, alu_carry, alu_overflow,
             alu_flag_we, alu_nv_from_rhs, flag_op, p_load, p_load_fast,
             p_load_data, push_brk, nmi_n, irq_n, poll, int_ack,
      input  p_flags, p_push, int_pending, int_is_nmi
   );

   modport slave (
      input  alu_valid, alu_result, alu_rhs, alu_carry, alu_overflow,
             alu_flag_we, alu_nv_from_rhs, flag_op, p_load, p_load_fast,
             p_load_data, push_brk, nmi_n, irq_n, poll, int_ack,
      output p_flags, p_push, int_pending, int_is_nmi
   );

endinterface

// File: rtl/core_nmi_edge.sv
// NMI falling-edge detector with a sticky latch; a new edge beats a clear.
module core_nmi_edge (
   input  logic clk,
   input  logic rst,
   input  logic nmi_n,
   input  logic clear,
   output logic nmi_latch
);

   logic nmi_prev;
   logic nmi_fall;

   assign nmi_fall = nmi_prev & ~nmi_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nmi_prev  <= 1'b1;
         nmi_latch <= 1'b0;
      end else begin
         nmi_prev <= nmi_n;
         if (nmi_fall)
            nmi_latch <= 1'b1;
         else if (clear)
            nmi_latch <= 1'b0;
      end
   end

endmodule

// File: rtl/core_status_unit.sv
// Q2A03 processor status register with ALU/flag-op/PLP updates and
// instruction-boundary NMI/IRQ sampling using delayed-I gating.
module core_status_unit
   import core_status_signals::*;
(
   input  logic               clk,
   input  logic               rst,
   core_status_unit_if.slave  bus
);

   logic [7:0] p_reg;
   logic [7:0] p_next;
   logic [7:0] alu_p;
   logic [7:0] alu_mask;
   logic [7:0] set_mask;
   logic [7:0] clr_mask;
   logic [7:0] p_mid;
   logic       i_gate;
   logic       nmi_latch;
   logic       nmi_clear;
   logic       nmi_post_ack;
   logic       int_pending_q;
   logic       int_is_nmi_q;

   // BIT copies operand bits 7/6 straight into N/V, which share those positions.
   always_comb begin
      alu_p = 8'h00;
      if (bus.alu_nv_from_rhs)
         alu_p = bus.alu_rhs & (flag_bit(flag_n) | flag_bit(flag_v));
      else
         alu_p = (bus.alu_result[7] ? flag_bit(flag_n) : 8'h00) |
                 (bus.alu_overflow  ? flag_bit(flag_v) : 8'h00);
      if (bus.alu_result == 8'h00)
         alu_p = alu_p | flag_bit(flag_z);
      if (bus.alu_carry)
         alu_p = alu_p | flag_bit(flag_c);
   end

   always_comb begin
      alu_mask = 8'h00;
      if (bus.alu_valid)
         alu_mask = (bus.alu_flag_we[3] ? flag_bit(flag_n) : 8'h00) |
                    (bus.alu_flag_we[2] ? flag_bit(flag_v) : 8'h00) |
                    (bus.alu_flag_we[1] ? flag_bit(flag_z) : 8'h00) |
                    (bus.alu_flag_we[0] ? flag_bit(flag_c) : 8'h00);
   end

   always_comb begin
      set_mask = 8'h00;
      clr_mask = 8'h00;
      case (bus.flag_op)
         op_clc:  clr_mask = flag_bit(flag_c);
         op_sec:  set_mask = flag_bit(flag_c);
         op_cli:  clr_mask = flag_bit(flag_i);
         op_sei:  set_mask = flag_bit(flag_i);
         op_cld:  clr_mask = flag_bit(flag_d);
         op_sed:  set_mask = flag_bit(flag_d);
         op_clv:  clr_mask = flag_bit(flag_v);
         default: ;
      endcase
   end

   // Layered so later stages win: ALU, then flag op, then stack load, then ack.
   always_comb begin
      p_mid  = (((p_reg & ~alu_mask) | (alu_p & alu_mask)) & ~clr_mask) | set_mask;
      p_next = bus.p_load ? bus.p_load_data : p_mid;
      if (bus.int_ack)
         p_next = p_next | flag_bit(flag_i);
      p_next = (p_next & stored_mask) | fixed_ones;
   end

   assign nmi_clear    = bus.int_ack & int_is_nmi_q;
   assign nmi_post_ack = nmi_latch & ~nmi_clear;

   core_nmi_edge u_nmi_edge (
      .clk       (clk),
      .rst       (rst),
      .nmi_n     (bus.nmi_n),
      .clear     (nmi_clear),
      .nmi_latch (nmi_latch)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_reg         <= RESET_P;
         i_gate        <= 1'b1;
         int_pending_q <= 1'b0;
         int_is_nmi_q  <= 1'b0;
      end else begin
         p_reg <= p_next;

         if (bus.p_load && bus.p_load_fast)
            i_gate <= p_next[flag_i];
         else if (bus.poll)
            i_gate <= p_reg[flag_i];

         // Poll samples with the gate value from before this poll's reload.
         if (bus.poll) begin
            int_pending_q <= nmi_post_ack | (~bus.irq_n & ~i_gate);
            int_is_nmi_q  <= nmi_post_ack;
         end else if (bus.int_ack) begin
            int_pending_q <= 1'b0;
            int_is_nmi_q  <= 1'b0;
         end
      end
   end

   assign bus.p_flags     = p_reg;
   assign bus.p_push      = (p_reg & ~flag_bit(flag_b)) |
                            (bus.push_brk ? flag_bit(flag_b) : 8'h00);
   assign bus.int_pending = int_pending_q;
   assign bus.int_is_nmi  = int_is_nmi_q;

endmodule

// File: tb/tb_core_status_unit.sv
// Directed bench for core_status_unit; expectations queued with each step
// and checked one cycle later against the outputs.
module tb_core_status_unit;
   import core_status_signals::*;

   localparam int k_p    = 0;
   localparam int k_push = 1;
   localparam int k_pend = 2;
   localparam int k_nmi  = 3;

   typedef struct {
      int         kind;
      logic [7:0] val;
      string      tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   core_status_unit_if bus ();

   core_status_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic expect_out(input int kind, input logic [7:0] val, input string tag);
      exp_t e;
      e.kind = kind;
      e.val  = val;
      e.tag  = tag;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t       e;
      logic [7:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.kind)
            k_p:     obs = bus.p_flags;
            k_push:  obs = bus.p_push;
            k_pend:  obs = {7'b0, bus.int_pending};
            default: obs = {7'b0, bus.int_is_nmi};
         endcase
         vectors++;
         assert (obs === e.val)
         else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic idle();
      bus.alu_valid       = 1'b0;
      bus.alu_nv_from_rhs = 1'b0;
      bus.alu_flag_we     = 4'b0000;
      bus.flag_op         = op_none;
      bus.p_load          = 1'b0;
      bus.p_load_fast     = 1'b0;
      bus.poll            = 1'b0;
      bus.int_ack         = 1'b0;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      drain();
      idle();
   endtask

   initial begin
      rst              = 1'b1;
      bus.alu_result   = 8'h00;
      bus.alu_rhs      = 8'h00;
      bus.alu_carry    = 1'b0;
      bus.alu_overflow = 1'b0;
      bus.p_load_data  = 8'h00;
      bus.push_brk     = 1'b1;
      bus.nmi_n        = 1'b1;
      bus.irq_n        = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      expect_out(k_p,    8'h24, "reset_p");
      expect_out(k_pend, 8'h00, "reset_pend");
      expect_out(k_nmi,  8'h00, "reset_nmi");
      drain();
      rst = 1'b0;

      // ALU zero result updates Z only
      bus.alu_valid = 1'b1; bus.alu_result = 8'h00; bus.alu_flag_we = 4'b0010;
      expect_out(k_p,    8'h26, "alu_z");
      expect_out(k_push, 8'h36, "push_brk1");
      cycle();

      // BIT: N/V from operand
      bus.alu_valid = 1'b1; bus.alu_rhs = 8'hC0; bus.alu_nv_from_rhs = 1'b1;
      bus.alu_flag_we = 4'b1110; bus.alu_result = 8'h00;
      expect_out(k_p, 8'hE6, "bit_nv");
      cycle();

      bus.alu_valid = 1'b1; bus.alu_carry = 1'b1; bus.alu_flag_we = 4'b0001;
      expect_out(k_p, 8'hE7, "alu_c_set");
      cycle();

      // CLC beats ALU carry write
      bus.flag_op = op_clc; bus.alu_valid = 1'b1; bus.alu_carry = 1'b1; bus.alu_flag_we = 4'b0001;
      expect_out(k_p, 8'hE6, "clc_over_alu");
      cycle();

      bus.p_load = 1'b1; bus.p_load_data = 8'hFF; bus.push_brk = 1'b0;
      expect_out(k_p,    8'hEF, "plp_ff");
      expect_out(k_push, 8'hEF, "push_irq");
      cycle();
      bus.push_brk = 1'b1;

      // No write enables: no change
      bus.alu_valid = 1'b1; bus.alu_carry = 1'b0; bus.alu_overflow = 1'b1; bus.alu_result = 8'h00;
      expect_out(k_p, 8'hEF, "alu_we_none");
      cycle();

      // p_load beats SEC
      bus.p_load = 1'b1; bus.p_load_data = 8'h04; bus.flag_op = op_sec;
      expect_out(k_p, 8'h24, "plp_over_sec");
      cycle();

      // CLI delayed by one poll
      bus.irq_n = 1'b0; bus.flag_op = op_cli;
      expect_out(k_p, 8'h20, "cli");
      cycle();
      bus.poll = 1'b1;
      expect_out(k_pend, 8'h00, "cli_poll1");
      cycle();
      bus.poll = 1'b1;
      expect_out(k_pend, 8'h01, "cli_poll2");
      expect_out(k_nmi,  8'h00, "cli_poll2_nmi");
      cycle();
      bus.int_ack = 1'b1;
      expect_out(k_pend, 8'h00, "irq_ack_pend");
      expect_out(k_p,    8'h24, "irq_ack_i");
      cycle();
      bus.irq_n = 1'b1; bus.poll = 1'b1;
      expect_out(k_pend, 8'h00, "idle_poll");
      cycle();
      bus.irq_n = 1'b0; bus.poll = 1'b1;
      expect_out(k_pend, 8'h00, "irq_masked");
      cycle();

      // RTI: fast I change seen by the very next poll
      bus.p_load = 1'b1; bus.p_load_fast = 1'b1; bus.p_load_data = 8'h00;
      expect_out(k_p, 8'h20, "rti_p");
      cycle();
      bus.poll = 1'b1;
      expect_out(k_pend, 8'h01, "rti_poll");
      expect_out(k_nmi,  8'h00, "rti_poll_nmi");
      cycle();
      bus.int_ack = 1'b1;
      expect_out(k_pend, 8'h00, "rti_ack");
      cycle();
      bus.irq_n = 1'b1;

      // NMI edge, take, no re-trigger while held low
      bus.nmi_n = 1'b0;
      expect_out(k_pend, 8'h00, "nmi_no_poll");
      cycle();
      bus.poll = 1'b1;
      expect_out(k_pend, 8'h01, "nmi_poll");
      expect_out(k_nmi,  8'h01, "nmi_poll_nmi");
      cycle();
      bus.int_ack = 1'b1;
      expect_out(k_pend, 8'h00, "nmi_ack_pend");
      expect_out(k_nmi,  8'h00, "nmi_ack_nmi");
      expect_out(k_p,    8'h24, "nmi_ack_i");
      cycle();
      bus.poll = 1'b1;
      expect_out(k_pend, 8'h00, "nmi_held_low");
      cycle();

      // NMI arriving during IRQ ack, then poll together with ack
      bus.nmi_n = 1'b1; bus.flag_op = op_cli; bus.irq_n = 1'b0;
      expect_out(k_p, 8'h20, "cli2");
      cycle();
      bus.poll = 1'b1;
      expect_out(k_pend, 8'h00, "cli2_poll1");
      cycle();
      bus.poll = 1'b1;
      expect_out(k_pend, 8'h01, "cli2_poll2");
      expect_out(k_nmi,  8'h00, "cli2_poll2_nmi");
      cycle();
      bus.int_ack = 1'b1; bus.nmi_n = 1'b0;
      expect_out(k_pend, 8'h00, "ack_with_edge");
      cycle();
      bus.poll = 1'b1;
      expect_out(k_pend, 8'h01, "nmi_after_irq");
      expect_out(k_nmi,  8'h01, "nmi_after_irq_nmi");
      cycle();
      bus.poll = 1'b1; bus.int_ack = 1'b1;
      expect_out(k_pend, 8'h00, "poll_ack_pend");
      expect_out(k_nmi,  8'h00, "poll_ack_nmi");
      expect_out(k_p,    8'h24, "poll_ack_p");
      cycle();
      bus.irq_n = 1'b1; bus.nmi_n = 1'b1;
      cycle();

      // Reset discards a latched NMI
      bus.nmi_n = 1'b0; bus.flag_op = op_sed;
      expect_out(k_p, 8'h2C, "sed");
      cycle();
      rst = 1'b1; bus.nmi_n = 1'b1;
      @(negedge clk);
      expect_out(k_p,    8'h24, "mid_reset_p");
      expect_out(k_pend, 8'h00, "mid_reset_pend");
      drain();
      rst = 1'b0;
      bus.poll = 1'b1;
      expect_out(k_pend, 8'h00, "nmi_discarded");
      cycle();

      // Edge and poll in the same cycle: seen at the next poll
      bus.nmi_n = 1'b0; bus.poll = 1'b1;
      expect_out(k_pend, 8'h00, "edge_with_poll");
      cycle();
      bus.poll = 1'b1;
      expect_out(k_pend, 8'h01, "edge_next_poll");
      expect_out(k_nmi,  8'h01, "edge_next_poll_nmi");
      cycle();
      bus.int_ack = 1'b1;
      expect_out(k_pend, 8'h00, "edge_ack");
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/core_status_unit.md
# core_status_unit

Processor status (P) register and interrupt-pending logic for the Q2A03 core. Sits directly downstream of the ALU: consumes its result, carry and overflow outputs and updates N/V/Z/C. Also executes the flag instructions (CLC/SEC/CLI/SEI/CLD/SED/CLV), PLP/RTI loads and PHP/BRK/interrupt push images. Samples NMI/IRQ at instruction-boundary poll strobes for the sequencer, with 6502 delayed-I semantics.

## Interface
- RESET_P, 8'h24: P value after reset (I=1, bit5=1).
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  apply ALU flag update this cycle.
- alu_result  in  8  ALU result byte.
- alu_rhs  in  8  ALU right operand, used for BIT.
- alu_carry  in  1  ALU carry out.
- alu_overflow  in  1  ALU overflow out.
- alu_flag_we  in  4  write enables {N,V,Z,C}.
- alu_nv_from_rhs  in  1  N,V taken from alu_rhs[7:6] instead of result/alu_overflow.
- flag_op  in  3  flag_op_type: none, clc, sec, cli, sei, cld, sed, clv.
- p_load  in  1  load P from p_load_data (PLP/RTI).
- p_load_fast  in  1  with p_load: I change visible to IRQ gating immediately (RTI).
- p_load_data  in  8  byte from stack.
- push_brk  in  1  bit4 of p_push (1 for PHP/BRK, 0 for IRQ/NMI).
- p_flags  out  8  current P: {N,V,1,0,D,I,Z,C}.
- p_push  out  8  {N,V,1,push_brk,D,I,Z,C}; combinational.
- nmi_n  in  1  NMI line, synchronous to clk, active low.
- irq_n  in  1  IRQ line, synchronous to clk, active low, level.
- poll  in  1  instruction-boundary strobe.
- int_pending  out  1  interrupt to be taken at next fetch.
- int_is_nmi  out  1  pending interrupt is NMI.
- int_ack  in  1  sequencer has entered interrupt sequence.

## Operation
- Stored flags: N V D I Z C. Bits 5/4 are not stored; p_load_data[5:4] ignored.
- ALU update (alu_valid=1): Z <= (alu_result==0); N <= alu_nv_from_rhs ? alu_rhs[7] : alu_result[7]; V <= alu_nv_from_rhs ? alu_rhs[6] : alu_overflow; C <= alu_carry; each only if its alu_flag_we bit is set.
- Same-cycle priority per flag: p_load > flag_op > ALU update. Non-conflicting flags merge. int_ack forces I=1 and overrides everything.
- NMI: falling edge of nmi_n (registered prev=1, now=0) sets nmi_latch. Cleared by int_ack while int_is_nmi=1. An edge arriving in the ack cycle still sets the latch (set wins).
- I gating: i_gate register. Loaded with I at each poll. Also loaded with the new I in the same cycle on p_load with p_load_fast=1. So CLI/SEI/PLP affect IRQ acceptance one poll later; RTI affects it immediately.
- On poll: int_pending <= nmi_latch | (!irq_n & !i_gate), using i_gate before this poll's update. int_is_nmi <= nmi_latch.
- int_ack clears int_pending and int_is_nmi. NMI arriving during an IRQ ack is taken at the following poll.

## Timing
- Reset values: P=RESET_P (p_flags=8'h24 default), nmi_latch=0, nmi prev=1, i_gate=1, int_pending=0, int_is_nmi=0. Reset mid-sequence discards any pending NMI.
- Flag updates: p_flags reflects them the cycle after the input. p_push is combinational from current state.
- poll to int_pending: 1 cycle. nmi_n edge to latch: 1 cycle. Edge plus poll in the same cycle is not seen until the next poll.
- poll together with int_ack: ack clears, then poll re-evaluates with the post-ack latch state (ack's I=1 is not yet in i_gate).

## Structure
- Package core_status_signals: flag bit indices (flag_c=0 … flag_n=7), flag_op_type enum, default RESET_P.
- Sub-module core_nmi_edge: edge detector plus set/clear latch.

## Test plan
- Reset, then release -> p_flags=8'h24, int_pending=0. Drive alu_valid, result 8'h00, we=4'b0010 -> p_flags=8'h26.
- BIT: alu_rhs=8'hC0, alu_nv_from_rhs=1, we=4'b1110, result 8'h00 -> p_flags=8'hE6.
- Same cycle flag_op=clc and ALU C write of 1 -> C=0. Next cycle p_load 8'hFF -> p_flags=8'hEF, p_push with push_brk=0 -> 8'hEF.
- I=1, irq_n=0, CLI then poll -> int_pending=0. Second poll -> int_pending=1, int_is_nmi=0.
- RTI: p_load_fast with data 8'h00 and irq_n=0, then poll -> int_pending=1 at the first poll.
- nmi_n 1->0 while I=1, poll -> int_pending=1, int_is_nmi=1. int_ack -> both 0, I=1. nmi_n held low, poll -> no re-trigger.
